// File: rtl/conv_pkg.sv
// Shared constants and types for the conv path: padding sentinel, fetch FSM
// encoding and the read-tag record carried alongside each RAM read.
package conv_pkg;

  localparam int          IMG_W     = 28;
  localparam int          ADDR_W    = 10;
  localparam int          IDX_W     = 4;
  localparam logic [9:0]  PAD_ADDR  = 10'h3FF;
  localparam logic [3:0]  LAST_SLOT = 4'd8;
  localparam logic [3:0]  COL2_SLOT = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             pad;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that carries each read slot's {valid, index, pad} tag so it
// emerges in the same cycle as the RAM data for that slot.
module rd_tag_pipe
  import conv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/patch_fetch.sv
// Fetch stage for the 3x3 conv window: latches nine patch addresses, reads the
// feature-map RAM one slot per cycle and assembles the window for the MAC array.
module patch_fetch #(
  parameter int         DW       = 8,
  parameter int         MEM_LAT  = 1,
  parameter logic [9:0] PAD_ADDR = 10'h3FF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load_full_patch,
  input  logic [9:0]    pixel_addr0,
  input  logic [9:0]    pixel_addr1,
  input  logic [9:0]    pixel_addr2,
  input  logic [9:0]    pixel_addr3,
  input  logic [9:0]    pixel_addr4,
  input  logic [9:0]    pixel_addr5,
  input  logic [9:0]    pixel_addr6,
  input  logic [9:0]    pixel_addr7,
  input  logic [9:0]    pixel_addr8,
  output logic          mem_rd_en,
  output logic [9:0]    mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] win0,
  output logic [DW-1:0] win1,
  output logic [DW-1:0] win2,
  output logic [DW-1:0] win3,
  output logic [DW-1:0] win4,
  output logic [DW-1:0] win5,
  output logic [DW-1:0] win6,
  output logic [DW-1:0] win7,
  output logic [DW-1:0] win8,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          busy,
  output logic [1:0]    dbg_state
);
  import conv_pkg::*;

  // Handshake: win_valid holds with a stable window until a cycle where
  // win_valid && win_ready; the FSM returns to IDLE on the next cycle.
  fetch_state_e  r_state;
  logic [3:0]    r_k;
  logic [9:0]    r_addr [9];
  logic [DW-1:0] r_win  [9];
  logic [9:0]    w_addr_in [9];
  logic          w_issue;
  logic          w_slot_pad;
  rd_tag_t       w_tag_in;
  rd_tag_t       w_tag_out;

  assign w_addr_in = '{pixel_addr0, pixel_addr1, pixel_addr2,
                       pixel_addr3, pixel_addr4, pixel_addr5,
                       pixel_addr6, pixel_addr7, pixel_addr8};

  assign w_issue    = (r_state == ST_ISSUE);
  assign w_slot_pad = (r_addr[r_k] == PAD_ADDR);
  assign w_tag_in   = '{valid: w_issue, idx: r_k, pad: w_slot_pad};

  // Pad slots still drive the sentinel on mem_addr, but never strobe the RAM.
  assign mem_rd_en = w_issue && !w_slot_pad;
  assign mem_addr  = w_issue ? r_addr[r_k] : '0;

  rd_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .i_clk (clk),
    .i_rst (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      for (int i = 0; i < 9; i++) begin
        r_addr[i] <= '0;
        r_win[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < 9; i++) r_addr[i] <= w_addr_in[i];
            if (load_full_patch) begin
              r_k <= '0;
            end else begin
              // Window slides one column: keep two columns, refetch the right one.
              for (int i = 0; i < 6; i++) r_win[i] <= r_win[i+3];
              r_k <= COL2_SLOT;
            end
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_k == LAST_SLOT) r_state <= ST_DRAIN;
          else                  r_k     <= r_k + 4'd1;
        end
        ST_DRAIN: begin
          if (w_tag_out.valid && w_tag_out.idx == LAST_SLOT) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (win_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_tag_out.valid && w_tag_out.idx <= LAST_SLOT)
        r_win[w_tag_out.idx] <= w_tag_out.pad ? '0 : mem_rdata;
    end
  end

  assign win0 = r_win[0];
  assign win1 = r_win[1];
  assign win2 = r_win[2];
  assign win3 = r_win[3];
  assign win4 = r_win[4];
  assign win5 = r_win[5];
  assign win6 = r_win[6];
  assign win7 = r_win[7];
  assign win8 = r_win[8];

  assign win_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_patch_fetch.sv
// Bench for patch_fetch: two instances (MEM_LAT 1 and 2), each behind a RAM
// model returning mem[a] = a[7:0]; windows checked against a column-level model.
module tb_patch_fetch;
  import conv_pkg::*;

  logic       clk;
  logic       rst;
  logic       start_s     [2];
  logic       full_s      [2];
  logic       win_ready_s [2];
  logic [9:0] addr_s      [2][9];
  logic       rd_en_s     [2];
  logic [9:0] mem_addr_s  [2];
  logic [7:0] win_s       [2][9];
  logic       win_valid_s [2];
  logic       busy_s      [2];
  logic [1:0] state_s     [2];

  logic [7:0] m_win [2][9];
  logic [7:0] exp_q [$];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] r_p1, r_p2;
    logic [7:0] w_rdata;
    // Non-read cycles return a marker so stray window writes become visible.
    always @(posedge clk) begin
      r_p1 <= rd_en_s[g] ? mem_addr_s[g][7:0] : 8'hEE;
      r_p2 <= r_p1;
    end
    assign w_rdata = (g == 0) ? r_p1 : r_p2;

    patch_fetch #(.DW(8), .MEM_LAT(g + 1), .PAD_ADDR(10'h3FF)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start_s[g]),
      .load_full_patch (full_s[g]),
      .pixel_addr0     (addr_s[g][0]),
      .pixel_addr1     (addr_s[g][1]),
      .pixel_addr2     (addr_s[g][2]),
      .pixel_addr3     (addr_s[g][3]),
      .pixel_addr4     (addr_s[g][4]),
      .pixel_addr5     (addr_s[g][5]),
      .pixel_addr6     (addr_s[g][6]),
      .pixel_addr7     (addr_s[g][7]),
      .pixel_addr8     (addr_s[g][8]),
      .mem_rd_en       (rd_en_s[g]),
      .mem_addr        (mem_addr_s[g]),
      .mem_rdata       (w_rdata),
      .win0            (win_s[g][0]),
      .win1            (win_s[g][1]),
      .win2            (win_s[g][2]),
      .win3            (win_s[g][3]),
      .win4            (win_s[g][4]),
      .win5            (win_s[g][5]),
      .win6            (win_s[g][6]),
      .win7            (win_s[g][7]),
      .win8            (win_s[g][8]),
      .win_valid       (win_valid_s[g]),
      .win_ready       (win_ready_s[g]),
      .busy            (busy_s[g]),
      .dbg_state       (state_s[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input logic [9:0] a);
    return (a == PAD_ADDR) ? 8'h00 : a[7:0];
  endfunction

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return PAD_ADDR;
    return 10'($urandom_range(0, IMG_W * IMG_W - 1));
  endfunction

  // One request on instance d; spur_cyc >= 1 injects an ignored start then.
  task automatic do_req(input int d, input bit full, input logic [9:0] a [9],
                        input int ready_delay, input int spur_cyc);
    int cyc, reads, exp_reads, slots, k;
    // Model: a full load reads every slot, a partial load slides by one column.
    if (full) begin
      for (int i = 0; i < 9; i++) m_win[d][i] = pix(a[i]);
    end else begin
      for (int i = 0; i < 6; i++) m_win[d][i] = m_win[d][i+3];
      for (int i = 6; i < 9; i++) m_win[d][i] = pix(a[i]);
    end
    for (int i = 0; i < 9; i++) exp_q.push_back(m_win[d][i]);
    slots = full ? 9 : 3;
    exp_reads = 0;
    for (int i = 9 - slots; i < 9; i++) if (a[i] != PAD_ADDR) exp_reads++;

    @(negedge clk);
    addr_s[d] = a; full_s[d] = full; start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    cyc = 1; reads = 0;
    check("busy_c1", busy_s[d], 1);
    while (!win_valid_s[d] && cyc < 40) begin
      if (rd_en_s[d]) reads++;
      if (cyc <= slots) begin
        k = cyc - 1 + 9 - slots;
        check("slot_en", rd_en_s[d], a[k] != PAD_ADDR);
        check("slot_addr", mem_addr_s[d], a[k]);
      end
      if (cyc == spur_cyc) begin
        start_s[d] = 1'b1; full_s[d] = !full;
        for (int i = 0; i < 9; i++) addr_s[d][i] = rand_addr();
      end else begin
        start_s[d] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_s[d] = 1'b0;
    check("valid_cycle", cyc, (full ? 10 : 4) + d + 1);
    check("read_count", reads, exp_reads);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check("win", win_s[d][i], e);
    end
    repeat (ready_delay) begin
      win_ready_s[d] = 1'b0;
      @(negedge clk);
      check("hold_valid", win_valid_s[d], 1);
      check("hold_busy", busy_s[d], 1);
      for (int i = 0; i < 9; i++) check("hold_win", win_s[d][i], m_win[d][i]);
    end
    win_ready_s[d] = 1'b1;
    @(negedge clk);
    win_ready_s[d] = 1'b0;
    check("post_valid", win_valid_s[d], 0);
    check("post_busy", busy_s[d], 0);
    check("post_state", state_s[d], ST_IDLE);
    for (int i = 0; i < 9; i++) check("post_win", win_s[d][i], m_win[d][i]);
  endtask

  task automatic reset_mid(input int d);
    logic [9:0] a [9];
    for (int i = 0; i < 9; i++) a[i] = 10'($urandom_range(0, IMG_W * IMG_W - 1));
    @(negedge clk);
    addr_s[d] = a; full_s[d] = 1'b1; start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int dd = 0; dd < 2; dd++)
      for (int i = 0; i < 9; i++) m_win[dd][i] = 8'h00;
    check("rst_busy", busy_s[d], 0);
    check("rst_valid", win_valid_s[d], 0);
    check("rst_rd_en", rd_en_s[d], 0);
    check("rst_addr", mem_addr_s[d], 0);
    for (int i = 0; i < 9; i++) check("rst_win", win_s[d][i], 0);
    repeat (4) @(negedge clk);
    check("rst_idle_busy", busy_s[d], 0);
    for (int i = 0; i < 9; i++) check("rst_no_write", win_s[d][i], 0);
  endtask

  initial begin
    logic [9:0] a [9];
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; full_s[d] = 1'b0; win_ready_s[d] = 1'b0;
      for (int i = 0; i < 9; i++) begin
        addr_s[d][i] = '0;
        m_win[d][i]  = 8'h00;
      end
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", busy_s[d], 0);
      check("reset_valid", win_valid_s[d], 0);
      check("reset_rd_en", rd_en_s[d], 0);
      check("reset_addr", mem_addr_s[d], 0);
      for (int i = 0; i < 9; i++) check("reset_win", win_s[d][i], 0);
    end
    rst = 1'b0;

    // Partial load straight out of reset shifts zeros in.
    a = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd5, 10'd33, 10'd61};
    do_req(1, 1'b0, a, 0, -1);

    a = '{10'd0, 10'd28, 10'd56, 10'd1, 10'd29, 10'd57, 10'd2, 10'd30, 10'd58};
    do_req(0, 1'b1, a, 0, -1);
    a[6] = 10'd3; a[7] = 10'd31; a[8] = 10'd59;
    do_req(0, 1'b0, a, 0, -1);

    a = '{PAD_ADDR, PAD_ADDR, PAD_ADDR, 10'd100, 10'd128, 10'd156, 10'd101, 10'd129, 10'd157};
    do_req(0, 1'b1, a, 0, -1);

    for (int i = 0; i < 9; i++) a[i] = 10'($urandom_range(0, IMG_W * IMG_W - 1));
    do_req(0, 1'b1, a, 7, -1);

    for (int i = 0; i < 9; i++) a[i] = 10'($urandom_range(0, IMG_W * IMG_W - 1));
    do_req(0, 1'b1, a, 0, 4);

    reset_mid(0);

    a = '{10'd0, 10'd28, 10'd56, 10'd1, 10'd29, 10'd57, 10'd2, 10'd30, 10'd58};
    do_req(1, 1'b1, a, 0, -1);
    a[6] = 10'd3; a[7] = 10'd31; a[8] = 10'd59;
    do_req(1, 1'b0, a, 2, -1);

    for (int n = 0; n < 24; n++) begin
      int d;
      d = $urandom_range(0, 1);
      for (int i = 0; i < 9; i++) a[i] = rand_addr();
      do_req(d, $urandom_range(0, 2) == 0, a, $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/patch_fetch.md
# patch_fetch

Fetch stage directly downstream of the 3x3 patch address generator in the conv path. Latches the nine patch addresses and the full/partial flag, reads pixels from the single-read-port feature-map RAM, and assembles a 3x3 window for the MAC array. On a partial load (same row, window slides one column) it shifts the held window left and fetches only the new right column, so issued reads drop from 9 to 3.

## Interface
- DW, 8, pixel width in bits
- MEM_LAT, 1, RAM read latency in cycles (legal: 1, 2)
- PAD_ADDR, 10'h3FF, sentinel address meaning zero padding (outside the 28x28 map)

- clk  input  1  clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: addresses and flag valid this cycle
- load_full_patch  input  1  1 = fetch all 9, 0 = shift and fetch column 6..8
- pixel_addr0..pixel_addr8  input  10 each  addr0..2 = left column rows m..m+2, 3..5 = middle, 6..8 = right
- mem_rd_en  output  1  RAM read strobe
- mem_addr  output  10  RAM read address
- mem_rdata  input  DW  RAM data, valid MEM_LAT cycles after mem_rd_en
- win0..win8  output  DW each  window, same indexing as addresses
- win_valid  output  1  window complete and stable
- win_ready  input  1  consumer accepts window
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: on start, latch all 9 addresses and flag; full -> index k = 0, partial -> win0..2 <= win3..5, win3..5 <= win6..8, k = 6; go ISSUE.
- ISSUE: one slot per cycle, mem_addr = addr[k]. addr[k] == PAD_ADDR -> mem_rd_en = 0 and slot tagged pad; else mem_rd_en = 1. k == 8 -> DRAIN, else k+1.
- Each slot pushes tag {k, pad} into an MEM_LAT-deep pipe; on tag exit, win[k] <= pad ? 0 : mem_rdata.
- DRAIN: when last tag (k = 8) writes, go HOLD.
- HOLD: win_valid = 1; win_ready -> IDLE. Window registers hold after exit (needed by next partial load).
- start outside IDLE is ignored, no latching, no side effects.
- Partial load after reset shifts zero-valued registers; no error flagged.
- Address range not checked other than PAD_ADDR equality.

## Timing
- Reset: state IDLE, win0..8 = 0, win_valid = 0, busy = 0, mem_rd_en = 0, mem_addr = 0, tag pipe cleared. Reset mid-ISSUE/DRAIN discards in-flight returns; no window write after reset.
- start sampled cycle 0; busy high from cycle 1.
- Full: slots cycles 1..9; win_valid rises cycle 10+MEM_LAT (11 for MEM_LAT=1).
- Partial: slots cycles 1..3; win_valid rises cycle 4+MEM_LAT (5 for MEM_LAT=1).
- win_valid and win0..8 stable while win_valid && !win_ready.
- Handshake cycle: win_valid && win_ready -> IDLE next cycle, busy low next cycle; earliest next accepted start is that IDLE cycle.
- mem_addr is don't-care when mem_rd_en = 0, except in pad slots, where it shows PAD_ADDR.

## Structure
- Shared package conv_pkg: IMG_W = 28, PAD_ADDR, fetch state encoding (2-bit), slot index width (4).
- Sub-module rd_tag_pipe: MEM_LAT-stage shift register of {valid, index[3:0], pad}, synchronous clear on rst.
- Top: FSM, address latch, window register file with shift path.

## Test plan
- RAM model mem[a] = a[7:0], MEM_LAT=1. Full load, addrs 0,28,56,1,29,57,2,30,58 -> win0..8 equal those values, win_valid at cycle 11, exactly 9 mem_rd_en pulses.
- Then partial, addr6..8 = 3,31,59 -> win = 1,29,57,2,30,58,3,31,59 at cycle 5, 3 reads only.
- Full load with addr0..2 = PAD_ADDR -> win0..2 = 0, mem_rd_en low cycles 1..3, win3..8 from RAM.
- Hold win_ready low 7 cycles in HOLD -> win_valid and window unchanged throughout; busy high; IDLE one cycle after win_ready.
- start pulse at cycle 4 of a full load -> ignored, window matches the first request, read count 9.
- rst asserted at cycle 5 of ISSUE -> all outputs reset next cycle, no window write from in-flight data; repeat the first scenario with MEM_LAT=2 -> win_valid at cycle 12.
